commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- In-order retirement stage of the out-of-order core. It is the reader of the reservation/reorder buffer.
- Scans buffer `entries` for the oldest tags in program order and retires up to 2 instructions per cycle. Retired results go to the architectural register file.
- Drives the commit signals back into the buffer: `is_really_commited`, `is_commited_store`, `commited_tags`.
- Owns the committed-store memory handshake, so stores retire only after memory accepts them.

Parameters:
- BUF_SIZE_LOG, 4: log2 of the buffer depth. Tag width is BUF_SIZE_LOG+1.
- BUF_SIZE, 2**BUF_SIZE_LOG: buffer entry count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- entries  in  BUF_SIZE x $bits(entry)  current buffer contents.
- is_really_commited  out  2  slot k retires this cycle.
- is_commited_store  out  2  retired slot k is a store.
- commited_tags  out  2 x (BUF_SIZE_LOG+1)  tag retired in slot k.
- rf_we  out  2  register-file write enable, slot k.
- rf_waddr  out  2 x 5  destination register, slot k.
- rf_wdata  out  2 x 32  result, slot k.
- st_valid  out  1  store request valid (registered).
- st_addr  out  32  store address, copied from entry.A.
- st_data  out  32  store data, copied from entry.Vk.
- st_mode  out  3  ldst_mode copied from entry.rwmm.
- st_ack  in  1  memory accepts the store this cycle.
- head_tag  out  BUF_SIZE_LOG+1  next tag to retire (debug/dispatch full check).

Behaviour:
- **Tags.** Tags are BUF_SIZE_LOG+1 bits. Tag 0 is never valid.
  - The head counter `head_tag` resets to 1.
  - It increments by 1 per retired instruction.
  - Wrap: 2*BUF_SIZE-1 → 1, skipping 0. Two retirements in one cycle wrap correctly, e.g. 30 → 31 → 1 when BUF_SIZE=16.
- **Lookup.** Combinational match of every entry against `head_tag` (slot 0) and `head_tag+1` with wrap (slot 1). Only entries with e_state != S_NOT_USED may match.
- **Slot eligibility.** A slot is eligible when:
  - its entry matched;
  - e_state == S_EXECUTED;
  - speculative_tag == 0, i.e. not under an unresolved branch.
- **Slot 1 retires only if** slot 0 retires in the same cycle, slot 1 is eligible, and slot 1 is not a STORE.
- **Non-store retirement (Unit != STORE), slot k:**
  - `is_really_commited[k]`=1 and `commited_tags[k]`=tag.
  - `rf_we[k]`=1 iff Dest != 0. In that case `rf_waddr`=Dest and `rf_wdata`=result.
- **Store FSM states:** S_IDLE, S_WAIT.
  - S_IDLE, slot 0 eligible and Unit==STORE: register `st_valid`=1 and `st_addr`/`st_data`/`st_mode` from the entry, then go to S_WAIT. Nothing retires that cycle.
  - S_WAIT: `st_valid` held at 1 with stable payload; no retirement other than the store.
  - S_WAIT with `st_ack`=1: that cycle slot 0 retires the store (`is_really_commited[0]`=1, `is_commited_store[0]`=1, `rf_we[0]`=0). `head_tag` increments by 1, `st_valid` goes to 0 next cycle, and the FSM returns to S_IDLE.
  - `st_ack` is ignored in S_IDLE.
  - A store at slot 1 is retired in a later cycle as slot 0. At most one store is retired per cycle.
- **Output timing.** Commit outputs (`is_really_commited`, `commited_tags`, `rf_*`) are combinational from `entries` and the registered state. The buffer clears retired entries in the same cycle.
- **Idle outputs.** When nothing retires, all `is_really_commited`, `is_commited_store` and `rf_we` = 0; tags and data are don't-care but are driven to 0.
- **Reset.**
  - `head_tag`=1, FSM=S_IDLE, `st_valid`=0, `st_addr`/`st_data`/`st_mode`=0.
  - All commit outputs are 0 during the reset cycle.
  - Reset mid S_WAIT drops the request without retiring it.
- **Empty / not-ready.** No match, or a head entry not yet executed, stalls retirement. `head_tag` holds.

Test Plan:
- Reset, then tag 1 executed ALU Dest=5 result=0xDEADBEEF → same cycle `is_really_commited[0]`=1, `commited_tags[0]`=1, `rf_we[0]`=1, `rf_waddr[0]`=5, `rf_wdata[0]`=0xDEADBEEF; `head_tag`=2 next.
- Tags 2 and 3 both executed, Dest=0 on tag 3 → both retire; `rf_we`=2'b01; `head_tag`=4. With tag 3 unexecuted, only tag 2 retires.
- Head is a store with A=0x100, Vk=0x55, rwmm=WORD → `st_valid`=1 next cycle with that payload. Hold `st_ack`=0 for 3 cycles → no retire and payload stable. Assert `st_ack` → tag retires with `is_commited_store[0]`=1; `st_valid`=0 next cycle.
- Head executed but speculative_tag=6'b000010 → no retire. Change speculative_tag to 0 → retires that cycle.
- `head_tag`=30 (BUF_SIZE=16), tags 30 and 31 executed → both retire, `head_tag`=1. Tag 0 is never matched.
- Assert reset while in S_WAIT → `st_valid`=0, `head_tag`=1 next cycle, and no commit pulse is observed.

Source files
------------

// File: rtl/commit_unit_if.sv
// Buffer entry types shared by the commit unit and its neighbours, plus the
// committed-store request/acknowledge bundle towards memory.
package commit_pkg;
  localparam int CU_BUF_SIZE_LOG = 4;
  localparam int CU_TAG_W        = CU_BUF_SIZE_LOG + 1;
  localparam logic [2:0] LDST_WORD = 3'b010;

  typedef enum logic [1:0] {S_NOT_USED, S_ISSUED, S_EXECUTED} e_state_t;
  typedef enum logic [1:0] {ALU, BRANCH, LOAD, STORE} unit_t;

  typedef struct packed {
    e_state_t              e_state;
    logic [CU_TAG_W-1:0]   tag;
    logic [CU_TAG_W:0]     speculative_tag;
    unit_t                 unit;
    logic [4:0]            dest;
    logic [31:0]           result;
    logic [31:0]           a;
    logic [31:0]           vk;
    logic [2:0]            rwmm;
  } entry_t;
endpackage

interface commit_unit_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_mode;
  logic        st_ack;

  modport master (output st_valid, st_addr, st_data, st_mode, input st_ack);
  modport slave  (input st_valid, st_addr, st_data, st_mode, output st_ack);
endinterface

// File: rtl/commit_unit.sv
// In-order retirement stage: retires up to two executed, non-speculative
// buffer entries per cycle; stores go out through a held request/ack handshake.
//
// state  | meaning
// S_IDLE | no store outstanding; ALU/branch/load entries retire freely
// S_WAIT | store request held on the bus; only its ack can retire it
module commit_unit
  import commit_pkg::*;
#(
  parameter int BUF_SIZE_LOG = CU_BUF_SIZE_LOG,
  parameter int BUF_SIZE     = 2**BUF_SIZE_LOG
) (
  input  logic                         clk,
  input  logic                         reset,
  input  entry_t                       entries [BUF_SIZE],
  output logic [1:0]                   is_really_commited,
  output logic [1:0]                   is_commited_store,
  output logic [1:0][BUF_SIZE_LOG:0]   commited_tags,
  output logic [1:0]                   rf_we,
  output logic [1:0][4:0]              rf_waddr,
  output logic [1:0][31:0]             rf_wdata,
  output logic [BUF_SIZE_LOG:0]        head_tag,
  commit_unit_if.master                st
);

  typedef enum logic {S_IDLE, S_WAIT} fsm_t;
  typedef logic [BUF_SIZE_LOG:0] tag_t;

  localparam tag_t TAG_MAX = {(BUF_SIZE_LOG+1){1'b1}};
  localparam tag_t TAG_ONE = {{BUF_SIZE_LOG{1'b0}}, 1'b1};

  // Tag 0 is reserved as "no tag", so the sequence wraps from max back to 1.
  function automatic tag_t tag_inc(input tag_t t);
    if (t == TAG_MAX) return TAG_ONE;
    return t + TAG_ONE;
  endfunction

  fsm_t        state, state_nxt;
  tag_t        tag1, tag2;
  entry_t      e0;
  logic        elig0, elig1;
  unit_t       unit1;
  logic [4:0]  dest1;
  logic [31:0] result1;
  logic [1:0]  n_ret;
  logic        st_load, st_done;
  logic        st_valid_q;
  logic [31:0] st_addr_q, st_data_q;
  logic [2:0]  st_mode_q;

  assign tag1 = tag_inc(head_tag);
  assign tag2 = tag_inc(tag1);

  always_comb begin
    e0      = '0;
    elig0   = 1'b0;
    elig1   = 1'b0;
    unit1   = ALU;
    dest1   = '0;
    result1 = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (entries[i].e_state != S_NOT_USED && entries[i].tag == head_tag) begin
        e0    = entries[i];
        elig0 = (entries[i].e_state == S_EXECUTED) && (entries[i].speculative_tag == '0);
      end
      if (entries[i].e_state != S_NOT_USED && entries[i].tag == tag1) begin
        elig1   = (entries[i].e_state == S_EXECUTED) && (entries[i].speculative_tag == '0);
        unit1   = entries[i].unit;
        dest1   = entries[i].dest;
        result1 = entries[i].result;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    is_really_commited = '0;
    is_commited_store  = '0;
    commited_tags      = '0;
    rf_we              = '0;
    rf_waddr           = '0;
    rf_wdata           = '0;
    n_ret              = 2'd0;
    st_load            = 1'b0;
    st_done            = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (elig0 && e0.unit == STORE) begin
            st_load   = 1'b1;
            state_nxt = S_WAIT;
          end else if (elig0) begin
            is_really_commited[0] = 1'b1;
            commited_tags[0]      = head_tag;
            n_ret                 = 2'd1;
            if (e0.dest != 5'd0) begin
              rf_we[0]    = 1'b1;
              rf_waddr[0] = e0.dest;
              rf_wdata[0] = e0.result;
            end
            if (elig1 && unit1 != STORE) begin
              is_really_commited[1] = 1'b1;
              commited_tags[1]      = tag1;
              n_ret                 = 2'd2;
              if (dest1 != 5'd0) begin
                rf_we[1]    = 1'b1;
                rf_waddr[1] = dest1;
                rf_wdata[1] = result1;
              end
            end
          end
        end
        S_WAIT: begin
          if (st.st_ack) begin
            is_really_commited[0] = 1'b1;
            is_commited_store[0]  = 1'b1;
            commited_tags[0]      = head_tag;
            n_ret                 = 2'd1;
            st_done               = 1'b1;
            state_nxt             = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      head_tag   <= TAG_ONE;
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      st_mode_q  <= '0;
    end else begin
      state <= state_nxt;
      case (n_ret)
        2'd1:    head_tag <= tag1;
        2'd2:    head_tag <= tag2;
        default: head_tag <= head_tag;
      endcase
      if (st_load) begin
        st_valid_q <= 1'b1;
        st_addr_q  <= e0.a;
        st_data_q  <= e0.vk;
        st_mode_q  <= e0.rwmm;
      end else if (st_done) begin
        st_valid_q <= 1'b0;
      end
    end
  end

  assign st.st_valid = st_valid_q;
  assign st.st_addr  = st_addr_q;
  assign st.st_data  = st_data_q;
  assign st.st_mode  = st_mode_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: a scoreboard of expected retirements is
// filled as buffer entries are staged and drained as commit pulses appear.
module tb_commit_unit;
  import commit_pkg::*;

  localparam int BL = 4;
  localparam int BS = 16;

  typedef struct {
    logic [4:0]  tag;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        st;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  entry_t           entries [BS];
  logic [1:0]       is_really_commited;
  logic [1:0]       is_commited_store;
  logic [1:0][4:0]  commited_tags;
  logic [1:0]       rf_we;
  logic [1:0][4:0]  rf_waddr;
  logic [1:0][31:0] rf_wdata;
  logic [4:0]       head_tag;

  commit_unit_if st_if ();

  commit_unit #(.BUF_SIZE_LOG(BL)) dut (
    .clk                (clk),
    .reset              (reset),
    .entries            (entries),
    .is_really_commited (is_really_commited),
    .is_commited_store  (is_commited_store),
    .commited_tags      (commited_tags),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .head_tag           (head_tag),
    .st                 (st_if.master)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int t, input e_state_t s, input logic [5:0] spec, input unit_t u,
                     input logic [4:0] d, input logic [31:0] r, input logic [31:0] a,
                     input logic [31:0] vk, input logic [2:0] m);
    entry_t e;
    e.e_state         = s;
    e.tag             = 5'(t);
    e.speculative_tag = spec;
    e.unit            = u;
    e.dest            = d;
    e.result          = r;
    e.a               = a;
    e.vk              = vk;
    e.rwmm            = m;
    entries[t % BS]   = e;
  endtask

  task automatic alu(input int t, input logic [4:0] d, input logic [31:0] r);
    put(t, S_EXECUTED, 6'd0, ALU, d, r, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic expect_rf(input int t, input logic [4:0] d, input logic [31:0] r);
    exp_t e;
    e.tag = 5'(t); e.we = (d != 5'd0); e.waddr = d; e.wdata = r; e.st = 1'b0;
    sb.push_back(e);
  endtask

  task automatic expect_st(input int t);
    exp_t e;
    e.tag = 5'(t); e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.st = 1'b1;
    sb.push_back(e);
  endtask

  task automatic clear_all();
    for (int i = 0; i < BS; i++) entries[i] = '0;
  endtask

  // Observe mid-cycle, then emulate the buffer freeing retired entries at the edge.
  task automatic cycle();
    logic [1:0]      clr_v;
    logic [1:0][4:0] clr_t;
    exp_t            e;
    clr_v = '0;
    clr_t = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (is_really_commited[k]) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 32'(is_really_commited), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("commit_tag", 32'(commited_tags[k]), 32'(e.tag));
          chk("rf_we", 32'(rf_we[k]), 32'(e.we));
          chk("is_store", 32'(is_commited_store[k]), 32'(e.st));
          if (e.we) begin
            chk("rf_waddr", 32'(rf_waddr[k]), 32'(e.waddr));
            chk("rf_wdata", rf_wdata[k], e.wdata);
          end
        end
        clr_v[k] = 1'b1;
        clr_t[k] = commited_tags[k];
      end
    end
    chk("store_flag_idle", 32'(is_commited_store & ~is_really_commited), 32'd0);
    chk("pending", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      if (clr_v[k]) entries[clr_t[k] % BS] = '0;
  endtask

  initial begin
    reset = 1'b1;
    st_if.st_ack = 1'b0;
    clear_all();
    alu(1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("reset_commit", 32'(is_really_commited), 32'd0);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_head", 32'(head_tag), 32'd1);
    chk("reset_st_valid", 32'(st_if.st_valid), 32'd0);
    chk("reset_st_addr", st_if.st_addr, 32'd0);
    reset = 1'b0;

    // single ALU retire
    expect_rf(1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    chk("head_after_1", 32'(head_tag), 32'd2);

    // dual retire, second without destination
    alu(2, 5'd7, 32'h1111_2222);
    alu(3, 5'd0, 32'h3333_4444);
    expect_rf(2, 5'd7, 32'h1111_2222);
    expect_rf(3, 5'd0, 32'h3333_4444);
    cycle();
    chk("head_after_3", 32'(head_tag), 32'd4);

    // second slot not yet executed
    alu(4, 5'd9, 32'h0000_0044);
    put(5, S_ISSUED, 6'd0, ALU, 5'd10, 32'h55, 32'd0, 32'd0, 3'd0);
    expect_rf(4, 5'd9, 32'h0000_0044);
    cycle();
    chk("head_after_4", 32'(head_tag), 32'd5);
    cycle();
    chk("head_stall_5", 32'(head_tag), 32'd5);
    alu(5, 5'd10, 32'h55);
    expect_rf(5, 5'd10, 32'h55);
    cycle();
    chk("head_after_5", 32'(head_tag), 32'd6);

    // store handshake with a ready ALU entry queued behind it
    put(6, S_EXECUTED, 6'd0, STORE, 5'd0, 32'd0, 32'h100, 32'h55, LDST_WORD);
    alu(7, 5'd3, 32'hCAFE_0007);
    cycle();
    chk("st_valid_issue", 32'(st_if.st_valid), 32'd1);
    chk("st_addr", st_if.st_addr, 32'h100);
    chk("st_data", st_if.st_data, 32'h55);
    chk("st_mode", 32'(st_if.st_mode), 32'(LDST_WORD));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("st_valid_hold", 32'(st_if.st_valid), 32'd1);
      chk("st_addr_hold", st_if.st_addr, 32'h100);
      chk("st_data_hold", st_if.st_data, 32'h55);
      chk("head_hold_st", 32'(head_tag), 32'd6);
    end
    st_if.st_ack = 1'b1;
    expect_st(6);
    cycle();
    st_if.st_ack = 1'b0;
    chk("st_valid_drop", 32'(st_if.st_valid), 32'd0);
    chk("head_after_st", 32'(head_tag), 32'd7);
    expect_rf(7, 5'd3, 32'hCAFE_0007);
    cycle();
    chk("head_after_7", 32'(head_tag), 32'd8);

    // ack while idle with nothing to retire
    st_if.st_ack = 1'b1;
    cycle();
    st_if.st_ack = 1'b0;
    chk("idle_ack_head", 32'(head_tag), 32'd8);
    chk("idle_ack_valid", 32'(st_if.st_valid), 32'd0);

    // speculative head blocks until resolved
    put(8, S_EXECUTED, 6'b000010, ALU, 5'd12, 32'h8888, 32'd0, 32'd0, 3'd0);
    cycle();
    chk("spec_hold", 32'(head_tag), 32'd8);
    alu(8, 5'd12, 32'h8888);
    expect_rf(8, 5'd12, 32'h8888);
    cycle();
    chk("spec_release", 32'(head_tag), 32'd9);

    // advance to the wrap point
    for (int t = 9; t < 29; t += 2) begin
      alu(t, 5'(t), 32'(t * 32'h0101));
      alu(t + 1, 5'(t + 1), 32'((t + 1) * 32'h0101));
      expect_rf(t, 5'(t), 32'(t * 32'h0101));
      expect_rf(t + 1, 5'(t + 1), 32'((t + 1) * 32'h0101));
      cycle();
    end
    alu(29, 5'd29, 32'h2929);
    expect_rf(29, 5'd29, 32'h2929);
    cycle();
    chk("head_30", 32'(head_tag), 32'd30);

    alu(30, 5'd1, 32'h3030_3030);
    alu(31, 5'd2, 32'h3131_3131);
    alu(0, 5'd4, 32'h0000_0BAD);
    expect_rf(30, 5'd1, 32'h3030_3030);
    expect_rf(31, 5'd2, 32'h3131_3131);
    cycle();
    chk("head_wrap", 32'(head_tag), 32'd1);
    cycle();
    chk("tag0_ignored", 32'(head_tag), 32'd1);
    clear_all();

    // reset while a store is outstanding
    put(1, S_EXECUTED, 6'd0, STORE, 5'd0, 32'd0, 32'h200, 32'h77, LDST_WORD);
    cycle();
    chk("st_valid_pre_rst", 32'(st_if.st_valid), 32'd1);
    reset = 1'b1;
    st_if.st_ack = 1'b1;
    cycle();
    chk("rst_wait_valid", 32'(st_if.st_valid), 32'd0);
    chk("rst_wait_head", 32'(head_tag), 32'd1);
    reset = 1'b0;
    st_if.st_ack = 1'b0;
    clear_all();
    cycle();
    chk("post_rst_valid", 32'(st_if.st_valid), 32'd0);
    chk("post_rst_head", 32'(head_tag), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
